// File: rtl/cfs_rx_ctrl.sv
// cfs_rx_ctrl: receive end of the MD interface.
// Accepts unaligned transfers from the MD RX master and checks each transfer's
// offset/size for legality. Legal transfers are packed as {size, offset, data}
// and pushed into the RX FIFO, then acknowledged with md_rx_ready. Illegal
// transfers are dropped and acknowledged with md_rx_ready + md_rx_err. Each
// drop also bumps a saturating 8-bit counter and pulses irq_drop.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   md_rx_valid/data/offset/size MD transfer request (sampled only in IDLE)
//   md_rx_ready, md_rx_err       one-cycle end-of-transfer response
//   push_valid, push_data        RX FIFO push request, packed word
//   push_ready                   RX FIFO accepts the word
//   cnt_drop, cnt_drop_clr       saturating drop counter and its sync clear
//   irq_drop                     one-cycle pulse per dropped transfer
// All outputs come straight from flops.
module cfs_rx_ctrl #(
  parameter  int unsigned ALGN_DATA_WIDTH   = 32,
  localparam int unsigned ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
  localparam int unsigned ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
  localparam int unsigned FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
  input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
  output logic                         md_rx_ready,
  output logic                         md_rx_err,
  output logic                         push_valid,
  output logic [FIFO_DATA_WIDTH-1:0]   push_data,
  input  logic                         push_ready,
  output logic [7:0]                   cnt_drop,
  input  logic                         cnt_drop_clr,
  output logic                         irq_drop
);

  localparam int unsigned BYTES = ALGN_DATA_WIDTH / 8;
  // SIZE_WIDTH >= OFFSET_WIDTH always, so one extra bit over the size field
  // holds offset+size and BYTES+offset without wrapping.
  localparam int unsigned MW    = ALGN_SIZE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    RESP_OK,
    RESP_ERR
  } state_t;

  state_t                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic                         err_q, err_d;
  logic                         irq_q, irq_d;
  logic                         push_valid_q, push_valid_d;
  logic [FIFO_DATA_WIDTH-1:0]   push_data_q, push_data_d;
  logic [7:0]                   cnt_q, cnt_d;

  logic [MW-1:0]                end_sum;
  logic [MW-1:0]                base;
  logic [MW-1:0]                divisor;
  logic [MW-1:0]                rem;
  logic                         legal;

  // Legality check. The divisor is forced to 1 when size is 0 so the modulo
  // never divides by zero; size==0 is rejected separately anyway.
  always_comb begin
    end_sum = MW'(md_rx_offset) + MW'(md_rx_size);
    base    = MW'(BYTES) + MW'(md_rx_offset);
    divisor = (md_rx_size == '0) ? MW'(1) : MW'(md_rx_size);
    rem     = base % divisor;
    legal   = (md_rx_size != '0) && (end_sum <= MW'(BYTES)) && (rem == '0);
  end

  always_comb begin
    state_d     = state_q;
    push_data_d = push_data_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (md_rx_valid) begin
          if (legal) begin
            state_d     = PUSH;
            push_data_d = {md_rx_size, md_rx_offset, md_rx_data};
          end else begin
            state_d = RESP_ERR;
          end
        end
      end
      PUSH: begin
        if (push_ready) state_d = RESP_OK;
      end
      RESP_OK:  state_d = IDLE;
      RESP_ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Counter moves on the same edge that enters RESP_ERR, so the new value
    // becomes visible together with the irq_drop pulse.
    if (state_d == RESP_ERR) begin
      if (cnt_drop_clr)         cnt_d = 8'd1;
      else if (cnt_q != '1)     cnt_d = cnt_q + 8'd1;
    end else if (cnt_drop_clr) begin
      cnt_d = '0;
    end

    // Outputs are registered versions of the next-state decode.
    push_valid_d = (state_d == PUSH);
    ready_d      = (state_d == RESP_OK) || (state_d == RESP_ERR);
    err_d        = (state_d == RESP_ERR);
    irq_d        = (state_d == RESP_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign md_rx_ready = ready_q;
  assign md_rx_err   = err_q;
  assign irq_drop    = irq_q;
  assign push_valid  = push_valid_q;
  assign push_data   = push_data_q;
  assign cnt_drop    = cnt_q;

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Self-checking bench for cfs_rx_ctrl (ALGN_DATA_WIDTH = 32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cfs_rx_ctrl;

  localparam int DW = 32;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int FW = DW + OW + SW;
  localparam int B  = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          md_rx_valid;
  logic [DW-1:0] md_rx_data;
  logic [OW-1:0] md_rx_offset;
  logic [SW-1:0] md_rx_size;
  logic          md_rx_ready;
  logic          md_rx_err;
  logic          push_valid;
  logic [FW-1:0] push_data;
  logic          push_ready;
  logic [7:0]    cnt_drop;
  logic          cnt_drop_clr;
  logic          irq_drop;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  cfs_rx_ctrl #(.ALGN_DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .cnt_drop     (cnt_drop),
    .cnt_drop_clr (cnt_drop_clr),
    .irq_drop     (irq_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference legality rule in plain integer arithmetic.
  function automatic bit is_legal(input int off, input int size);
    if (size == 0) return 1'b0;
    if (off + size > B) return 1'b0;
    return ((B + off) % size) == 0;
  endfunction

  function automatic logic [63:0] pack(input int off, input int size, input logic [31:0] data);
    return (64'(size) << (DW + OW)) | (64'(off) << DW) | 64'(data);
  endfunction

  // One full transfer: present it for one edge, stall the FIFO `stall`
  // cycles, then check the response and the return to idle.
  task automatic xfer(input int off, input int size, input logic [31:0] data,
                      input int stall, input bit clr);
    bit leg;
    logic [63:0] exp_word;
    leg      = is_legal(off, size);
    exp_word = pack(off, size, data);
    md_rx_valid  = 1'b1;
    md_rx_offset = OW'(off);
    md_rx_size   = SW'(size);
    md_rx_data   = data;
    push_ready   = (stall == 0);
    cnt_drop_clr = clr;
    if (!leg)     exp_cnt = clr ? 1 : ((exp_cnt >= 255) ? 255 : exp_cnt + 1);
    else if (clr) exp_cnt = 0;
    step();
    // Scribble the MD inputs; they must be ignored from here on.
    md_rx_valid  = 1'b0;
    cnt_drop_clr = 1'b0;
    md_rx_data   = $urandom;
    md_rx_offset = OW'($urandom);
    md_rx_size   = SW'($urandom);
    if (leg) begin
      check("push_valid", push_valid, 1);
      check("push_data", push_data, exp_word);
      check("ready_early", md_rx_ready, 0);
      check("irq_ok", irq_drop, 0);
      for (int i = 0; i < stall; i++) begin
        step();
        check("stall_push_valid", push_valid, 1);
        check("stall_push_data", push_data, exp_word);
        check("stall_ready", md_rx_ready, 0);
      end
      push_ready = 1'b1;
      step();
      check("ok_ready", md_rx_ready, 1);
      check("ok_err", md_rx_err, 0);
      check("ok_push_done", push_valid, 0);
      check("ok_irq", irq_drop, 0);
      push_ready = 1'($urandom);
      step();
      check("ok_ready_end", md_rx_ready, 0);
      check("ok_err_end", md_rx_err, 0);
      check("ok_idle_push", push_valid, 0);
    end else begin
      check("err_ready", md_rx_ready, 1);
      check("err_err", md_rx_err, 1);
      check("err_irq", irq_drop, 1);
      check("err_no_push", push_valid, 0);
      check("err_cnt", cnt_drop, exp_cnt);
      step();
      check("err_ready_end", md_rx_ready, 0);
      check("err_err_end", md_rx_err, 0);
      check("err_irq_end", irq_drop, 0);
    end
    check("cnt_drop", cnt_drop, exp_cnt);
  endtask

  initial begin
    int off, size;
    logic [31:0] d0, d1;

    reset_n      = 1'b0;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    push_ready   = 1'b0;
    cnt_drop_clr = 1'b0;
    #1;
    check("rst_ready", md_rx_ready, 0);
    check("rst_err", md_rx_err, 0);
    check("rst_push_valid", push_valid, 0);
    check("rst_push_data", push_data, 0);
    check("rst_cnt", cnt_drop, 0);
    check("rst_irq", irq_drop, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Aligned full-word transfer.
    xfer(0, 4, 32'hDEADBEEF, 0, 0);

    // Illegal set.
    xfer(1, 2, $urandom, 0, 0);
    xfer(3, 2, $urandom, 0, 0);
    xfer(2, 3, $urandom, 0, 0);
    xfer(0, 0, $urandom, 0, 0);
    check("cnt_after_illegal_set", cnt_drop, 4);

    // FIFO stall of 5 cycles.
    xfer(2, 2, $urandom, 5, 0);

    // Random mix.
    for (int n = 0; n < 60; n++) begin
      xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom,
           int'($urandom_range(0, 3)), 1'b0);
    end

    // Standalone clear.
    cnt_drop_clr = 1'b1;
    step();
    cnt_drop_clr = 1'b0;
    exp_cnt = 0;
    check("clr_alone", cnt_drop, 0);

    // Saturation: 256 drops, then a drop together with a clear.
    for (int n = 0; n < 256; n++) begin
      do begin
        off  = int'($urandom_range(0, 3));
        size = int'($urandom_range(0, 7));
      end while (is_legal(off, size));
      xfer(off, size, $urandom, 0, 0);
    end
    check("cnt_saturated", cnt_drop, 255);
    xfer(3, 2, $urandom, 0, 1);
    check("cnt_clr_with_drop", cnt_drop, 1);

    // Back-to-back with valid held high.
    d0 = $urandom;
    d1 = $urandom;
    md_rx_valid  = 1'b1;
    md_rx_offset = 2'd1;
    md_rx_size   = 3'd1;
    md_rx_data   = d0;
    push_ready   = 1'b1;
    step();
    check("b2b_push0", push_valid, 1);
    check("b2b_data0", push_data, pack(1, 1, d0));
    md_rx_offset = 2'd0;
    md_rx_size   = 3'd4;
    md_rx_data   = d1;
    step();
    check("b2b_ready0", md_rx_ready, 1);
    check("b2b_err0", md_rx_err, 0);
    step();
    check("b2b_gap_ready", md_rx_ready, 0);
    check("b2b_gap_push", push_valid, 0);
    step();
    check("b2b_push1", push_valid, 1);
    check("b2b_data1", push_data, pack(0, 4, d1));
    md_rx_valid = 1'b0;
    step();
    check("b2b_ready1", md_rx_ready, 1);
    check("b2b_err1", md_rx_err, 0);
    step();
    check("b2b_ready1_end", md_rx_ready, 0);

    // Asynchronous reset in the middle of a stalled push.
    md_rx_valid  = 1'b1;
    md_rx_offset = 2'd0;
    md_rx_size   = 3'd4;
    md_rx_data   = $urandom;
    push_ready   = 1'b0;
    step();
    md_rx_valid = 1'b0;
    check("pre_rst_push", push_valid, 1);
    check("pre_rst_cnt", cnt_drop, exp_cnt);
    #2 reset_n = 1'b0;
    #1;
    check("async_push_valid", push_valid, 0);
    check("async_push_data", push_data, 0);
    check("async_ready", md_rx_ready, 0);
    check("async_cnt", cnt_drop, 0);
    exp_cnt = 0;
    step();
    reset_n = 1'b1;
    push_ready = 1'b1;
    step();
    check("post_rst_idle", push_valid, 0);
    xfer(0, 4, $urandom, 1, 0);
    xfer(1, 3, $urandom, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfs_rx_ctrl.md
Name: cfs_rx_ctrl

Overview:
RX controller, the receive end of the MD interface. It accepts unaligned transfers from the MD RX master and checks each transfer's offset/size for legality. Legal transfers are packed and pushed into the RX FIFO; illegal ones are dropped and answered with an error response. It also keeps a saturating drop counter and a drop interrupt pulse for the register block.

Parameters:
ALGN_DATA_WIDTH, 32, MD data width in bits; power of 2, >= 8.
ALGN_OFFSET_WIDTH (derived), 1 if ALGN_DATA_WIDTH <= 8 else log2(ALGN_DATA_WIDTH/8), offset field width.
ALGN_SIZE_WIDTH (derived), log2(ALGN_DATA_WIDTH/8)+1, size field width.
FIFO_DATA_WIDTH (derived), ALGN_DATA_WIDTH+ALGN_OFFSET_WIDTH+ALGN_SIZE_WIDTH, RX FIFO word width.

Ports:
clk  input  1  clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
md_rx_valid  input  1  MD master has a transfer pending
md_rx_data  input  ALGN_DATA_WIDTH  transfer data
md_rx_offset  input  ALGN_OFFSET_WIDTH  byte offset of first valid byte
md_rx_size  input  ALGN_SIZE_WIDTH  number of valid bytes
md_rx_ready  output  1  one-cycle end-of-transfer response
md_rx_err  output  1  error flag; meaningful only when md_rx_ready=1
push_valid  output  1  RX FIFO push request
push_data  output  FIFO_DATA_WIDTH  packed word: [data | offset | size], data at the LSBs, size at the MSBs
push_ready  input  1  RX FIFO accepts the word
cnt_drop  output  8  saturating count of dropped (illegal) transfers
cnt_drop_clr  input  1  synchronous clear of cnt_drop
irq_drop  output  1  one-cycle pulse per dropped transfer

Behaviour:
- Reset (async, reset_n=0): state=IDLE; md_rx_ready=0, md_rx_err=0, push_valid=0, push_data=0, cnt_drop=0, irq_drop=0. Any in-flight transfer is lost with no response.
- All outputs are registered; none is combinational from any input.
- Legality check is combinational on the md_rx_* inputs, with B = ALGN_DATA_WIDTH/8. A transfer is legal iff all hold:
  - size != 0
  - offset + size <= B, evaluated with one extra bit so there is no wrap
  - (B + offset) % size == 0
- FSM states: IDLE, PUSH, RESP_OK, RESP_ERR.
- IDLE, md_rx_valid=1 and legal: capture {data, offset, size} into push_data, set push_valid=1, go to PUSH.
- IDLE, md_rx_valid=1 and illegal: go to RESP_ERR. Data is discarded.
- IDLE, md_rx_valid=0: stay in IDLE.
- PUSH: hold push_valid=1 and push_data stable until push_ready=1. On push_valid&push_ready, clear push_valid and go to RESP_OK. No timeout applies.
- RESP_OK: md_rx_ready=1, md_rx_err=0 for exactly one cycle, then IDLE.
- RESP_ERR: md_rx_ready=1, md_rx_err=1 and irq_drop=1 for exactly one cycle. cnt_drop increments in the same cycle. Then IDLE.
- Latency, valid seen in IDLE at cycle N:
  - legal, push_ready=1: push_valid high in N+1, md_rx_ready in N+2
  - illegal: md_rx_ready/md_rx_err in N+1
- In the cycle after a response the FSM is back in IDLE. A new transfer presented there (valid held high with new fields) is evaluated that cycle, so the back-to-back rate is one transfer per 3 cycles.
- MD inputs are sampled only in IDLE. Changes to md_rx_* in PUSH or the RESP states are ignored; the response always refers to the captured transfer.
- cnt_drop:
  - saturates at 255; irq_drop still pulses when saturated
  - cnt_drop_clr alone sets it to 0 next cycle
  - cnt_drop_clr together with an increment gives 1
- md_rx_err is 0 whenever md_rx_ready=0.

Test Plan:
1. ALGN_DATA_WIDTH=32, offset=0, size=4, data=0xDEADBEEF, push_ready=1 -> push_valid cycle N+1 with push_data={size=4, offset=0, 0xDEADBEEF}; md_rx_ready=1, md_rx_err=0 at N+2; cnt_drop stays 0.
2. Illegal set, one transfer each: (off=1,size=2), (off=3,size=2), (off=2,size=3), (off=0,size=0) -> each gets ready=1, err=1 one cycle after valid, no push_valid, irq_drop pulse; cnt_drop ends at 4.
3. Legal offset=2, size=2, push_ready held 0 for 5 cycles then 1 -> push_valid and push_data stable for 6 cycles; md_rx_ready exactly one cycle after the push handshake. Changing md_rx_data during the stall has no effect.
4. 256 illegal transfers, then cnt_drop_clr asserted in the same cycle as the 257th drop -> cnt_drop stays 255 from the 255th drop on; after the clear it is 1. irq_drop pulses for every drop.
5. Back-to-back legal transfers with valid held high (off=1,size=1 then off=0,size=4) -> both pushed in order, two responses 3 cycles apart, err=0.
6. reset_n deasserted while in PUSH -> push_valid, md_rx_ready and cnt_drop go to 0 immediately (asynchronously). After release the FSM is in IDLE and the next legal transfer completes normally.
